matrix_operand_store: RTL and testbench

// - Responder side of the sequential matrix multiplier's operand/result interface.
// - Holds operand matrices A and B and serves them on the multiplier's element indices.
// - Accepts each z_out/z_stb result strobe with a z_ack pulse and stores it in result matrix C.
// - Sequences a run (load -> start -> collect -> done) and exposes C for readout.

---
 rtl/matrix_operand_store.sv | 180 ++++++++++++++++++
 tb/tb_matrix_operand_store.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_store.sv
// Operand/result store for the sequential matrix multiplier: serves A/B, collects C, sequences runs.
// Optional MATRIX_STORE_CHECK_EN: per-run z_ack counter, err if mm_done arrives after != M^3 acks.
module matrix_operand_store #(
  parameter int M      = 4,
  parameter int IDX_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic              ld_sel,
  input  logic [IDX_W-1:0]  ld_row,
  input  logic [IDX_W-1:0]  ld_col,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              go,
  output logic              mm_start,
  input  logic              mm_done,
  input  logic [IDX_W-1:0]  a_i,
  input  logic [IDX_W-1:0]  a_j,
  input  logic [IDX_W-1:0]  b_i,
  input  logic [IDX_W-1:0]  b_j,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  input  logic [DATA_W-1:0] z_in,
  input  logic [IDX_W-1:0]  z_i,
  input  logic [IDX_W-1:0]  z_j,
  input  logic              z_stb,
  output logic              z_ack,
  input  logic [IDX_W-1:0]  rd_row,
  input  logic [IDX_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              result_valid,
  output logic              err
);

  localparam int AW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDX_W:0] LIM = (IDX_W+1)'(M);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_a [M][M];
  logic [DATA_W-1:0] r_b [M][M];
  logic [DATA_W-1:0] r_c [M][M];

  logic              r_z_ack;
  logic              r_mm_start;
  logic              r_result_valid;
  logic              r_err;
  logic [DATA_W-1:0] r_rd_data;

  logic w_enter_run;
  logic w_ld_en;
  logic w_done;
  logic w_z_take;
  logic w_ld_ok;
  logic w_z_ok;
  logic w_cnt_err;
  logic w_err_evt;

  function automatic logic in_rng(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return ({1'b0, r} < LIM) && ({1'b0, c} < LIM);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_LOAD;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enter_run = 1'b0;
    w_ld_en     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_ld_en = ld_valid;
        if (go) begin
          w_state_nxt = S_RUN;
          w_enter_run = 1'b1;
        end
      end
      S_RUN: begin
        if (mm_done) begin
          w_state_nxt = S_DONE;
          w_done      = 1'b1;
        end
      end
      S_DONE: begin
        // go takes priority; a simultaneous operand write is dropped
        if (go) begin
          w_state_nxt = S_RUN;
          w_enter_run = 1'b1;
        end else if (ld_valid) begin
          w_state_nxt = S_LOAD;
          w_ld_en     = 1'b1;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign w_z_take = (r_state == S_RUN) && z_stb && !r_z_ack;
  assign w_ld_ok  = in_rng(ld_row, ld_col);
  assign w_z_ok   = in_rng(z_i, z_j);

`ifdef MATRIX_STORE_CHECK_EN
  localparam int CW = $clog2(M*M*M+1);
  localparam logic [CW:0] CNT_FULL = (CW+1)'(M*M*M);

  logic [CW-1:0] r_ack_cnt;
  logic [CW:0]   w_cnt_seen;

  // include an ack still on the port when mm_done lands
  assign w_cnt_seen = {1'b0, r_ack_cnt} + (CW+1)'(r_z_ack);
  assign w_cnt_err  = w_done && (w_cnt_seen != CNT_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_ack_cnt <= '0;
    else if (w_enter_run)                    r_ack_cnt <= '0;
    else if (r_z_ack && (r_ack_cnt != '1))   r_ack_cnt <= r_ack_cnt + 1'b1;
  end
`else
  assign w_cnt_err = 1'b0;
`endif

  assign w_err_evt = (w_ld_en && !w_ld_ok) ||
                     (z_stb && (r_state != S_RUN)) ||
                     (w_z_take && !w_z_ok) ||
                     w_cnt_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < M; i++) begin
        for (int unsigned j = 0; j < M; j++) begin
          r_a[i][j] <= '0;
          r_b[i][j] <= '0;
          r_c[i][j] <= '0;
        end
      end
      r_z_ack        <= 1'b0;
      r_mm_start     <= 1'b0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_rd_data      <= '0;
    end else begin
      r_mm_start <= w_enter_run;
      r_z_ack    <= w_z_take;
      if (w_enter_run) begin
        for (int unsigned i = 0; i < M; i++) begin
          for (int unsigned j = 0; j < M; j++) begin
            r_c[i][j] <= '0;
          end
        end
      end else if (w_z_take && w_z_ok) begin
        r_c[z_i[AW-1:0]][z_j[AW-1:0]] <= z_in;
      end
      if (w_ld_en && w_ld_ok) begin
        if (ld_sel) r_b[ld_row[AW-1:0]][ld_col[AW-1:0]] <= ld_data;
        else        r_a[ld_row[AW-1:0]][ld_col[AW-1:0]] <= ld_data;
      end
      if (w_enter_run || w_ld_en) r_result_valid <= 1'b0;
      else if (w_done)            r_result_valid <= 1'b1;
      if (w_err_evt) r_err <= 1'b1;
      r_rd_data <= in_rng(rd_row, rd_col) ? r_c[rd_row[AW-1:0]][rd_col[AW-1:0]] : '0;
    end
  end

  assign a_out        = in_rng(a_i, a_j) ? r_a[a_i[AW-1:0]][a_j[AW-1:0]] : '0;
  assign b_out        = in_rng(b_i, b_j) ? r_b[b_i[AW-1:0]][b_j[AW-1:0]] : '0;
  assign ld_ready     = (r_state != S_RUN);
  assign mm_start     = r_mm_start;
  assign z_ack        = r_z_ack;
  assign rd_data      = r_rd_data;
  assign result_valid = r_result_valid;
  assign err          = r_err;

endmodule

// File: tb/tb_matrix_operand_store.sv
// Directed bench for matrix_operand_store (M=4); reference model kept as plain arrays and run flags.
module tb_matrix_operand_store;
  localparam int M  = 4;
  localparam int IW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0, ld_sel = 1'b0;
  logic [IW-1:0] ld_row = '0, ld_col = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          go = 1'b0, mm_start, mm_done = 1'b0;
  logic [IW-1:0] a_i = '0, a_j = '0, b_i = '0, b_j = '0;
  logic [DW-1:0] a_out, b_out;
  logic [DW-1:0] z_in = '0;
  logic [IW-1:0] z_i = '0, z_j = '0;
  logic          z_stb = 1'b0, z_ack;
  logic [IW-1:0] rd_row = '0, rd_col = '0;
  logic [DW-1:0] rd_data;
  logic          result_valid, err;

  matrix_operand_store #(.M(M), .IDX_W(IW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_row(ld_row), .ld_col(ld_col),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .go(go), .mm_start(mm_start), .mm_done(mm_done),
    .a_i(a_i), .a_j(a_j), .b_i(b_i), .b_j(b_j), .a_out(a_out), .b_out(b_out),
    .z_in(z_in), .z_i(z_i), .z_j(z_j), .z_stb(z_stb), .z_ack(z_ack),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: DONE is exactly "result_valid and not running"
  logic [DW-1:0] mA [M][M];
  logic [DW-1:0] mB [M][M];
  logic [DW-1:0] mC [M][M];
  bit running, exp_rv, exp_err, cmp_en;
  int acks;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rdm(input int which, input logic [IW-1:0] r, input logic [IW-1:0] c);
    if (r >= IW'(M) || c >= IW'(M)) return '0;
    case (which)
      0:       return mA[r[1:0]][c[1:0]];
      1:       return mB[r[1:0]][c[1:0]];
      default: return mC[r[1:0]][c[1:0]];
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        mA[i][j] = '0; mB[i][j] = '0; mC[i][j] = '0;
      end
    running = 0; exp_rv = 0; exp_err = 0; acks = 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_out", a_out, rdm(0, a_i, a_j));
      chk("b_out", b_out, rdm(1, b_i, b_j));
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, !running});
      chk("result_valid", {31'b0, result_valid}, {31'b0, exp_rv});
      chk("err", {31'b0, err}, {31'b0, exp_err});
    end
  end

  // all tasks start and end one time unit after a rising edge
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic ld(input logic sel, input logic [IW-1:0] r, input logic [IW-1:0] c, input logic [DW-1:0] d);
    ld_valid = 1'b1; ld_sel = sel; ld_row = r; ld_col = c; ld_data = d;
    @(posedge clk);
    if (!running) begin
      if (r < IW'(M) && c < IW'(M)) begin
        if (sel) mB[r[1:0]][c[1:0]] = d;
        else     mA[r[1:0]][c[1:0]] = d;
      end else exp_err = 1;
      exp_rv = 0;
    end
    #1 ld_valid = 1'b0;
  endtask

  task automatic go_run(input bit with_ld);
    go = 1'b1;
    if (with_ld) begin
      ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 5'd1; ld_col = 5'd2; ld_data = 32'hDEADBEEF;
    end
    @(posedge clk);
    running = 1; exp_rv = 0; acks = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) mC[i][j] = '0;
    #1 go = 1'b0; ld_valid = 1'b0;
    chk("mm_start_pulse", {31'b0, mm_start}, 32'd1);
    @(posedge clk);
    #1 chk("mm_start_end", {31'b0, mm_start}, 32'd0);
  endtask

  task automatic z_one(input logic [IW-1:0] i, input logic [IW-1:0] j, input logic [DW-1:0] v);
    z_stb = 1'b1; z_i = i; z_j = j; z_in = v;
    chk("z_ack_pre", {31'b0, z_ack}, 32'd0);
    @(posedge clk);
    if (running) begin
      acks++;
      if (i < IW'(M) && j < IW'(M)) mC[i[1:0]][j[1:0]] = v;
      else exp_err = 1;
    end else exp_err = 1;
    #1 z_stb = 1'b0;
    chk("z_ack", {31'b0, z_ack}, {31'b0, running});
    @(posedge clk);
    #1 chk("z_ack_low", {31'b0, z_ack}, 32'd0);
  endtask

  task automatic done();
    mm_done = 1'b1;
    @(posedge clk);
    if (running) begin
      running = 0; exp_rv = 1;
`ifdef MATRIX_STORE_CHECK_EN
      if (acks != M*M*M) exp_err = 1;
`endif
    end
    #1 mm_done = 1'b0;
  endtask

  task automatic rd_chk(input logic [IW-1:0] r, input logic [IW-1:0] c);
    rd_row = r; rd_col = c;
    @(posedge clk);
    #1 chk("rd_data", rd_data, rdm(2, r, c));
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    #1 cmp_en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("rst_z_ack", {31'b0, z_ack}, 32'd0);
    chk("rst_mm_start", {31'b0, mm_start}, 32'd0);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        a_i = IW'(i); a_j = IW'(j);
        #1 chk("rst_a_out", a_out, 32'd0);
      end
    rst = 1'b1;
    @(posedge clk); #1;

    // operand load and serve
    ld(1'b0, 5'd1, 5'd2, 32'h3F800000);
    ld(1'b1, 5'd3, 5'd0, 32'h40000000);
    ld(1'b0, 5'd0, 5'd0, 32'h11111111);
    ld(1'b1, 5'd2, 5'd2, 32'h22222222);
    a_i = 5'd1; a_j = 5'd2; b_i = 5'd3; b_j = 5'd0;
    #1 chk("a_out_lit", a_out, 32'h3F800000);
    chk("b_out_lit", b_out, 32'h40000000);
    @(posedge clk); #1;
    b_i = 5'd4; @(posedge clk); #1;
    b_i = 5'd2; b_j = 5'd2; @(posedge clk); #1;

    // first run: full 64 acks
    go_run(0);
    chk("ld_ready_run", {31'b0, ld_ready}, 32'd0);
    ld(1'b0, 5'd1, 5'd2, 32'hDEADBEEF);
    chk("a_out_run_ld", a_out, 32'h3F800000);
    z_one(5'd2, 5'd3, 32'h40400000);
    // held strobe: acks every other edge, the second accepted value lands
    z_stb = 1'b1; z_i = 5'd0; z_j = 5'd1; z_in = 32'hA0000001;
    @(posedge clk); #1 chk("held_ack1", {31'b0, z_ack}, 32'd1);
    z_in = 32'hA0000002;
    @(posedge clk); #1 chk("held_ack2", {31'b0, z_ack}, 32'd0);
    z_in = 32'hA0000003;
    @(posedge clk); #1 chk("held_ack3", {31'b0, z_ack}, 32'd1);
    z_stb = 1'b0;
    mC[0][1] = 32'hA0000003; acks += 2;
    @(posedge clk); #1 chk("held_ack4", {31'b0, z_ack}, 32'd0);
    a_i = 5'd7;
    for (int n = 0; n < 61; n++) begin
      int idx;
      idx = (n % 16 == 11) ? 15 : n % 16;
      z_one(IW'(idx / 4), IW'(idx % 4), 32'hC0000000 + DW'(n));
    end
    a_i = 5'd1;
    done();
    chk("rv_after_64", {31'b0, result_valid}, 32'd1);
    chk("err_after_64", {31'b0, err}, 32'd0);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) rd_chk(IW'(r), IW'(c));
    rd_chk(5'd5, 5'd0);
    rd_row = 5'd2; rd_col = 5'd3;
    @(posedge clk); #1 chk("rd_lit", rd_data, 32'h40400000);

    // rerun from DONE with a colliding write; 63 acks
    go_run(1);
    chk("go_wins", a_out, 32'h3F800000);
    for (int n = 0; n < 63; n++) z_one(IW'((n / 4) % 4), IW'(n % 4), DW'(n));
    done();
`ifdef MATRIX_STORE_CHECK_EN
    chk("err_after_63", {31'b0, err}, 32'd1);
`else
    chk("err_after_63", {31'b0, err}, 32'd0);
`endif
    ld(1'b1, 5'd1, 5'd1, 32'h12345678);
    b_i = 5'd1; b_j = 5'd1;
    #1 chk("ld_from_done", b_out, 32'h12345678);
    chk("rv_cleared", {31'b0, result_valid}, 32'd0);

    // asynchronous reset mid-run while z_ack is high
    do_reset();
    ld(1'b0, 5'd1, 5'd2, 32'h3F800000);
    go_run(0);
    for (int n = 0; n < 10; n++) z_one(IW'(n % 4), 5'd0, 32'h55000000 + DW'(n));
    rd_row = 5'd0; rd_col = 5'd0;
    z_stb = 1'b1; z_i = 5'd1; z_j = 5'd1; z_in = 32'h77777777;
    @(posedge clk);
    #2 chk("ack_before_rst", {31'b0, z_ack}, 32'd1);
    rst = 1'b0; model_reset();
    z_stb = 1'b0;
    #1 chk("ack_async_drop", {31'b0, z_ack}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_ld_ready2", {31'b0, ld_ready}, 32'd1);
    a_i = 5'd1; a_j = 5'd2;
    #1 chk("rst_a_cleared", a_out, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // range and out-of-state errors, each from a clean reset
    ld(1'b0, 5'd4, 5'd0, 32'hBAD0BAD0);
    chk("ld_oor_err", {31'b0, err}, 32'd1);
    do_reset();
    z_one(5'd0, 5'd0, 32'hBAD1BAD1);
    chk("z_load_err", {31'b0, err}, 32'd1);
    do_reset();
    go_run(0);
    z_one(5'd4, 5'd3, 32'hAAAA0001);
    z_one(5'd1, 5'd4, 32'hAAAA0002);
    done();
    rd_chk(5'd0, 5'd3);
    rd_chk(5'd1, 5'd0);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
